vga_fade_stage: RTL and testbench

Registered output stage between the background colour mux and the VGA PMOD pins. It re-times the 2-bit R/G/B and the hsync/vsync pair by one clock and forces blanking outside the visible area. It also scales colour by a global brightness level (0..3) that a frame-locked fade-in/fade-out state machine steps once every `FRAMES_PER_STEP` frames. The peripheral register block drives its commands, and it reports fade completion as a one-cycle pulse suitable for an interrupt.

---
 rtl/vga_fade_stage.sv | 173 +++++++++++++++++
 tb/tb_vga_fade_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fade_stage.sv
`default_nettype none
// ============================================================================
// Module      : vga_fade_stage
// Description : Registered VGA output stage. Re-times 2-bit RGB and the
//               hsync/vsync pair by one clock and forces colour to black
//               outside the visible area. Colour is scaled by a global
//               brightness level (0..3). A frame-locked state machine fades
//               the level in or out one step every FRAMES_PER_STEP frames
//               and reports completion with a one-cycle pulse.
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_r/in_g/in_b        - 2-bit colour from background mux
//               in_hsync/in_vsync     - syncs from timing generator
//               in_visible            - active-video flag
//               cmd_valid/cmd/cmd_level - command from register block
//                                       (00 nop, 01 fade-in, 10 fade-out,
//                                        11 set level)
//               out_r/out_g/out_b     - scaled, blanked colour
//               out_hsync/out_vsync   - delayed syncs
//               level                 - current brightness
//               busy                  - fade in progress
//               fade_done             - one-cycle fade-complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fade_stage #(
  parameter int         FRAMES_PER_STEP = 4,
  parameter bit         VSYNC_ACTIVE    = 1'b1,
  parameter logic [1:0] RESET_LEVEL     = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] in_r,
  input  logic [1:0] in_g,
  input  logic [1:0] in_b,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_visible,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [1:0] cmd_level,
  output logic [1:0] out_r,
  output logic [1:0] out_g,
  output logic [1:0] out_b,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [1:0] level,
  output logic       busy,
  output logic       fade_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    FADE_OUT = 2'd2
  } state_t;

  localparam logic [1:0] CMD_FADE_IN  = 2'd1;
  localparam logic [1:0] CMD_FADE_OUT = 2'd2;
  localparam logic [1:0] CMD_SET      = 2'd3;
  localparam logic [7:0] LAST_COUNT   = 8'(FRAMES_PER_STEP - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] level_nxt;
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_nxt;
  logic       done_nxt;
  logic       vsync_prev;
  logic       tick;

  // floor(c * lvl / 3) as a small table
  function automatic logic [1:0] scale(input logic [1:0] c, input logic [1:0] lvl);
    logic [1:0] res;
    case (lvl)
      2'd3:    res = c;
      2'd2:    res = (c == 2'd3) ? 2'd2 : ((c == 2'd2) ? 2'd1 : 2'd0);
      2'd1:    res = (c == 2'd3) ? 2'd1 : 2'd0;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // Frame start: vsync enters its active level. The history register
  // resets to the active level so a held-active vsync after reset is not
  // mistaken for a new frame.
  assign tick = (in_vsync == VSYNC_ACTIVE) && (vsync_prev != VSYNC_ACTIVE);

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    level_nxt     = level;
    frame_cnt_nxt = frame_cnt;
    done_nxt      = 1'b0;

    // Commands take priority; a tick arriving in the same cycle is dropped.
    if (cmd_valid && (cmd == CMD_SET)) begin
      level_nxt     = cmd_level;
      state_nxt     = IDLE;
      frame_cnt_nxt = 8'd0;
    end else if (cmd_valid && (cmd == CMD_FADE_IN)) begin
      frame_cnt_nxt = 8'd0;
      if (level == 2'd3) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = FADE_IN;
      end
    end else if (cmd_valid && (cmd == CMD_FADE_OUT)) begin
      frame_cnt_nxt = 8'd0;
      if (level == 2'd0) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = FADE_OUT;
      end
    end else if (tick && (state != IDLE)) begin
      if (frame_cnt == LAST_COUNT) begin
        frame_cnt_nxt = 8'd0;
        if (state == FADE_IN) begin
          level_nxt = level + 2'd1;
          if (level == 2'd2) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          level_nxt = level - 2'd1;
          if (level == 2'd1) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end else begin
        frame_cnt_nxt = frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      level      <= RESET_LEVEL;
      frame_cnt  <= 8'd0;
      fade_done  <= 1'b0;
      vsync_prev <= VSYNC_ACTIVE;
    end else begin
      state      <= state_nxt;
      level      <= level_nxt;
      frame_cnt  <= frame_cnt_nxt;
      fade_done  <= done_nxt;
      vsync_prev <= in_vsync;
    end
  end

  // Pixel path uses the level register before this edge's update, so a new
  // level shows on pixels sampled in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r     <= 2'd0;
      out_g     <= 2'd0;
      out_b     <= 2'd0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
    end else begin
      out_r     <= in_visible ? scale(in_r, level) : 2'd0;
      out_g     <= in_visible ? scale(in_g, level) : 2'd0;
      out_b     <= in_visible ? scale(in_b, level) : 2'd0;
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fade_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fade_stage
// Description : Directed self-checking bench for vga_fade_stage with
//               FRAMES_PER_STEP=2. Pixel expectations are queued when the
//               stimulus is driven and popped when the registered output
//               appears; control outputs are checked against fixed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fade_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] in_r = 2'd0, in_g = 2'd0, in_b = 2'd0;
  logic       in_hsync = 1'b0, in_vsync = 1'b0, in_visible = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0, cmd_level = 2'd0;
  logic [1:0] out_r, out_g, out_b, level;
  logic       out_hsync, out_vsync, busy, fade_done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
  } pix_t;

  pix_t exp_q[$];

  vga_fade_stage #(
    .FRAMES_PER_STEP(2),
    .VSYNC_ACTIVE(1'b1),
    .RESET_LEVEL(2'd3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_visible(in_visible),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_level(cmd_level),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hsync(out_hsync), .out_vsync(out_vsync),
    .level(level), .busy(busy), .fade_done(fade_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [1:0] model_scale(input logic [1:0] c, input logic [1:0] l);
    int p;
    p = (int'(c) * int'(l)) / 3;
    return p[1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [1:0] lv, input logic bz, input logic dn);
    chk({tag, "_level"}, {6'd0, level}, {6'd0, lv});
    chk({tag, "_busy"}, {7'd0, busy}, {7'd0, bz});
    chk({tag, "_done"}, {7'd0, fade_done}, {7'd0, dn});
  endtask

  // Drive one pixel, queue its expected output, then compare after the edge.
  task automatic pix(input string tag, input logic [1:0] r, input logic [1:0] g,
                     input logic [1:0] b, input logic hs, input logic vs,
                     input logic vis, input logic [1:0] lv);
    pix_t e;
    pix_t o;
    in_r = r; in_g = g; in_b = b;
    in_hsync = hs; in_vsync = vs; in_visible = vis;
    e.r  = vis ? model_scale(r, lv) : 2'd0;
    e.g  = vis ? model_scale(g, lv) : 2'd0;
    e.b  = vis ? model_scale(b, lv) : 2'd0;
    e.hs = hs;
    e.vs = vs;
    exp_q.push_back(e);
    step();
    o = {out_r, out_g, out_b, out_hsync, out_vsync};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s obs=%0h exp=queue_entry", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
      end
    end
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [1:0] l);
    cmd_valid = 1'b1; cmd = c; cmd_level = l;
    step();
    cmd_valid = 1'b0; cmd = 2'd0; cmd_level = 2'd0;
  endtask

  // One low cycle, then a rising vsync sampled at the next edge.
  task automatic tick();
    in_vsync = 1'b0;
    step();
    in_vsync = 1'b1;
    step();
    in_vsync = 1'b0;
  endtask

  initial begin
    // Reset
    #12;
    chk("rst_out_r", {6'd0, out_r}, 8'd0);
    chk("rst_hsync", {7'd0, out_hsync}, 8'd0);
    ctl("rst", 2'd3, 1'b0, 1'b0);
    #4 rst_n = 1'b1;
    step();

    // Passthrough and blanking
    pix("pass", 2'd3, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 2'd3);
    pix("blank", 2'd3, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 2'd3);
    pix("blank_hs0", 2'd3, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 2'd3);

    // Scaling
    do_cmd(2'd3, 2'd2);
    ctl("set2", 2'd2, 1'b0, 1'b0);
    pix("lvl2", 2'd3, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 2'd2);
    do_cmd(2'd3, 2'd1);
    pix("lvl1", 2'd3, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1);
    do_cmd(2'd3, 2'd0);
    pix("lvl0", 2'd3, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 2'd0);
    in_visible = 1'b0;

    // Fade-out 3 -> 0 over 6 vsync rising edges
    do_cmd(2'd3, 2'd3);
    do_cmd(2'd2, 2'd0);
    ctl("fo_start", 2'd3, 1'b1, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      ctl($sformatf("fo_edge%0d", e), 2'(3 - e / 2), (e < 6), (e == 6));
    end
    step();
    ctl("fo_after", 2'd0, 1'b0, 1'b0);

    // Reversal: fade-out at level 1 with one tick counted, then fade-in
    do_cmd(2'd3, 2'd1);
    do_cmd(2'd2, 2'd0);
    tick();
    ctl("rev_pre", 2'd1, 1'b1, 1'b0);
    do_cmd(2'd1, 2'd0);
    ctl("rev_cmd", 2'd1, 1'b1, 1'b0);
    tick();
    ctl("rev_t1", 2'd1, 1'b1, 1'b0);
    tick();
    ctl("rev_t2", 2'd2, 1'b1, 1'b0);
    tick();
    ctl("rev_t3", 2'd2, 1'b1, 1'b0);
    tick();
    ctl("rev_t4", 2'd3, 1'b0, 1'b1);
    step();
    chk("rev_done_once", {7'd0, fade_done}, 8'd0);

    // Collision: command and tick in the same cycle
    do_cmd(2'd2, 2'd0);
    tick();
    ctl("col_pre", 2'd3, 1'b1, 1'b0);
    in_vsync = 1'b0;
    step();
    in_vsync = 1'b1;
    do_cmd(2'd2, 2'd0);
    in_vsync = 1'b0;
    ctl("col_cmd", 2'd3, 1'b1, 1'b0);
    tick();
    ctl("col_t1", 2'd3, 1'b1, 1'b0);
    tick();
    ctl("col_t2", 2'd2, 1'b1, 1'b0);

    // Set level aborts fade without a pulse
    do_cmd(2'd3, 2'd3);
    ctl("abort", 2'd3, 1'b0, 1'b0);
    step();
    chk("abort_nopulse", {7'd0, fade_done}, 8'd0);

    // Fade-in at level 3: no busy, immediate done pulse
    do_cmd(2'd1, 2'd0);
    ctl("fi_met", 2'd3, 1'b0, 1'b1);
    step();
    ctl("fi_met_after", 2'd3, 1'b0, 1'b0);

    // Set level during fade-out
    do_cmd(2'd2, 2'd0);
    ctl("fo2_start", 2'd3, 1'b1, 1'b0);
    do_cmd(2'd3, 2'd2);
    ctl("fo2_set", 2'd2, 1'b0, 1'b0);
    step();
    chk("fo2_nopulse", {7'd0, fade_done}, 8'd0);

    // Asynchronous reset mid-fade
    do_cmd(2'd3, 2'd1);
    do_cmd(2'd2, 2'd0);
    in_r = 2'd3; in_visible = 1'b1; in_hsync = 1'b1;
    step();
    chk("ar_pre_hs", {7'd0, out_hsync}, 8'd1);
    chk("ar_pre_busy", {7'd0, busy}, 8'd1);
    #2 rst_n = 1'b0;
    in_vsync = 1'b1;
    #1;
    chk("ar_out_r", {6'd0, out_r}, 8'd0);
    chk("ar_hsync", {7'd0, out_hsync}, 8'd0);
    ctl("ar_in", 2'd3, 1'b0, 1'b0);
    step();
    #3 rst_n = 1'b1;
    in_visible = 1'b0; in_hsync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      ctl($sformatf("ar_rel%0d", i), 2'd3, 1'b0, 1'b0);
    end
    in_vsync = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
